// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: run/pause/lap/clear FSM, gates the 1 s pulse generator and
// accumulates its ticks into a BCD MM:SS value for the seven-segment driver.
module stopwatch_ctrl #(
   parameter int MAX_MIN = 59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_start_stop,
   input  logic       btn_clear,
   input  logic       btn_lap,
   input  logic       pulse_1s,
   output logic       enable_pulse_1s,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [3:0] min_tens,
   output logic       running,
   output logic       lap_active,
   output logic       overflow
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_LAP   = 2'd3
   } state_t;

   typedef struct packed {
      logic [3:0] mt;
      logic [3:0] mo;
      logic [3:0] st;
      logic [3:0] so;
   } bcd_t;

   typedef struct packed {
      logic wrap;
      bcd_t val;
   } bcd_step_t;

   localparam logic [3:0] MAX_MIN_T = 4'(MAX_MIN / 10);
   localparam logic [3:0] MAX_MIN_O = 4'(MAX_MIN % 10);

   state_t    r_state;
   state_t    w_state_nx;
   logic      r_ss_prev;
   logic      r_clr_prev;
   logic      r_lap_prev;
   logic      w_ss_press;
   logic      w_clr_press;
   logic      w_lap_press;
   logic      w_counting;
   logic      w_tick;
   logic      w_capture;
   logic      w_overflow_nx;
   bcd_step_t w_inc;
   bcd_t      r_live;
   bcd_t      r_hold;
   bcd_t      r_disp;
   bcd_t      w_live_nx;
   bcd_t      w_hold_nx;
   bcd_t      w_disp_nx;
   logic      r_enable;
   logic      r_running;
   logic      r_lap_active;
   logic      r_overflow;

   // One-second BCD increment; minutes wrap to 00:00 after MAX_MIN:59.
   function automatic bcd_step_t bcd_inc(input bcd_t v);
      bcd_step_t r;
      r.wrap = 1'b0;
      r.val  = v;
      if (v.so != 4'd9) begin
         r.val.so = v.so + 4'd1;
      end else begin
         r.val.so = 4'd0;
         if (v.st != 4'd5) begin
            r.val.st = v.st + 4'd1;
         end else begin
            r.val.st = 4'd0;
            if ((v.mt == MAX_MIN_T) && (v.mo == MAX_MIN_O)) begin
               r.val.mt = 4'd0;
               r.val.mo = 4'd0;
               r.wrap   = 1'b1;
            end else if (v.mo != 4'd9) begin
               r.val.mo = v.mo + 4'd1;
            end else begin
               r.val.mo = 4'd0;
               r.val.mt = v.mt + 4'd1;
            end
         end
      end
      return r;
   endfunction

   assign w_ss_press  = btn_start_stop & ~r_ss_prev;
   assign w_clr_press = btn_clear & ~r_clr_prev;
   assign w_lap_press = btn_lap & ~r_lap_prev;

   always_comb begin
      w_state_nx = r_state;
      if (w_clr_press) begin
         w_state_nx = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (w_ss_press) w_state_nx = S_RUN;
            S_RUN: begin
               if (w_ss_press)       w_state_nx = S_PAUSE;
               else if (w_lap_press) w_state_nx = S_LAP;
            end
            S_PAUSE: if (w_ss_press) w_state_nx = S_RUN;
            S_LAP: begin
               if (w_ss_press)       w_state_nx = S_PAUSE;
               else if (w_lap_press) w_state_nx = S_RUN;
            end
         endcase
      end
   end

   // A tick is judged on the current state, so one arriving as RUN is left still counts.
   always_comb begin
      w_counting    = (r_state == S_RUN) || (r_state == S_LAP);
      w_tick        = pulse_1s & w_counting & ~w_clr_press;
      w_capture     = (r_state == S_RUN) && (w_state_nx == S_LAP);
      w_inc         = bcd_inc(r_live);
      w_overflow_nx = w_tick & w_inc.wrap;

      w_live_nx = r_live;
      w_hold_nx = r_hold;
      if (w_clr_press) begin
         w_live_nx = '0;
         w_hold_nx = '0;
      end else begin
         if (w_tick)    w_live_nx = w_inc.val;
         if (w_capture) w_hold_nx = r_live;
      end

      w_disp_nx = (w_state_nx == S_LAP) ? w_hold_nx : w_live_nx;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_ss_prev    <= 1'b0;
         r_clr_prev   <= 1'b0;
         r_lap_prev   <= 1'b0;
         r_live       <= '0;
         r_hold       <= '0;
         r_disp       <= '0;
         r_enable     <= 1'b0;
         r_running    <= 1'b0;
         r_lap_active <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_state      <= w_state_nx;
         r_ss_prev    <= btn_start_stop;
         r_clr_prev   <= btn_clear;
         r_lap_prev   <= btn_lap;
         r_live       <= w_live_nx;
         r_hold       <= w_hold_nx;
         r_disp       <= w_disp_nx;
         r_enable     <= (w_state_nx == S_RUN) || (w_state_nx == S_LAP);
         r_running    <= (w_state_nx == S_RUN) || (w_state_nx == S_LAP);
         r_lap_active <= (w_state_nx == S_LAP);
         r_overflow   <= w_overflow_nx;
      end
   end

   assign enable_pulse_1s = r_enable;
   assign sec_ones        = r_disp.so;
   assign sec_tens        = r_disp.st;
   assign min_ones        = r_disp.mo;
   assign min_tens        = r_disp.mt;
   assign running         = r_running;
   assign lap_active      = r_lap_active;
   assign overflow        = r_overflow;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl built with MAX_MIN=1 so the wrap is reachable.
module tb_stopwatch_ctrl;

   localparam int TB_MAX = 1;

   typedef struct {
      string      name;
      logic [19:0] v;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       btn_ss;
   logic       btn_clr;
   logic       btn_lap;
   logic       pulse;
   logic       en;
   logic [3:0] so, st, mo, mt;
   logic       run_o;
   logic       lap_o;
   logic       ovf;

   int   n_chk = 0;
   int   n_err = 0;
   exp_t sb[$];

   stopwatch_ctrl #(.MAX_MIN(TB_MAX)) dut (
      .clk             (clk),
      .rst             (rst),
      .btn_start_stop  (btn_ss),
      .btn_clear       (btn_clr),
      .btn_lap         (btn_lap),
      .pulse_1s        (pulse),
      .enable_pulse_1s (en),
      .sec_ones        (so),
      .sec_tens        (st),
      .min_ones        (mo),
      .min_tens        (mt),
      .running         (run_o),
      .lap_active      (lap_o),
      .overflow        (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   function automatic logic [15:0] bcd(input int n);
      int m, s, w;
      w = n % ((TB_MAX + 1) * 60);
      m = w / 60;
      s = w % 60;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic logic [19:0] mk(input logic [15:0] d, input logic e, input logic r,
                                      input logic l, input logic o);
      return {d, e, r, l, o};
   endfunction

   function automatic logic [19:0] obs();
      return {mt, mo, st, so, en, run_o, lap_o, ovf};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      rst = 1'b0;
      repeat (5) cyc();
      sb.push_back('{"reset_hold", mk(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0)});
      e = sb.pop_front(); n_chk++;
      if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
      rst = 1'b1;
      pulse = 1'b1;
      sb.push_back('{"idle_tick_ignored", mk(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0)});
      cyc();
      pulse = 1'b0;
      e = sb.pop_front(); n_chk++;
      if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
   endtask

   task automatic test_run();
      exp_t e;
      sb.push_back('{"start_enable", mk(bcd(0), 1'b1, 1'b1, 1'b0, 1'b0)});
      btn_ss = 1'b1; cyc(); btn_ss = 1'b0;
      e = sb.pop_front(); n_chk++;
      if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
      for (int i = 1; i <= 3; i++) begin
         repeat (9) cyc();
         sb.push_back('{"run_tick", mk(bcd(i), 1'b1, 1'b1, 1'b0, 1'b0)});
         pulse = 1'b1; cyc(); pulse = 1'b0;
         e = sb.pop_front(); n_chk++;
         if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
      end
   endtask

   task automatic test_pause();
      exp_t e;
      cyc();
      sb.push_back('{"pause_enter", mk(bcd(3), 1'b0, 1'b0, 1'b0, 1'b0)});
      btn_ss = 1'b1; cyc(); btn_ss = 1'b0;
      e = sb.pop_front(); n_chk++;
      if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
      for (int i = 0; i < 2; i++) begin
         repeat (4) cyc();
         sb.push_back('{"pause_tick_ignored", mk(bcd(3), 1'b0, 1'b0, 1'b0, 1'b0)});
         pulse = 1'b1; cyc(); pulse = 1'b0;
         e = sb.pop_front(); n_chk++;
         if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
      end
      sb.push_back('{"held_single_press", mk(bcd(3), 1'b1, 1'b1, 1'b0, 1'b0)});
      btn_ss = 1'b1; repeat (20) cyc(); btn_ss = 1'b0;
      e = sb.pop_front(); n_chk++;
      if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
      cyc();
      sb.push_back('{"resume_tick", mk(bcd(4), 1'b1, 1'b1, 1'b0, 1'b0)});
      pulse = 1'b1; cyc(); pulse = 1'b0;
      e = sb.pop_front(); n_chk++;
      if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
   endtask

   task automatic test_lap();
      exp_t e;
      cyc();
      sb.push_back('{"pre_lap_tick", mk(bcd(5), 1'b1, 1'b1, 1'b0, 1'b0)});
      pulse = 1'b1; cyc(); pulse = 1'b0;
      e = sb.pop_front(); n_chk++;
      if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
      cyc();
      sb.push_back('{"lap_enter", mk(bcd(5), 1'b1, 1'b1, 1'b1, 1'b0)});
      btn_lap = 1'b1; cyc(); btn_lap = 1'b0;
      e = sb.pop_front(); n_chk++;
      if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
      for (int i = 0; i < 4; i++) begin
         cyc();
         sb.push_back('{"lap_frozen", mk(bcd(5), 1'b1, 1'b1, 1'b1, 1'b0)});
         pulse = 1'b1; cyc(); pulse = 1'b0;
         e = sb.pop_front(); n_chk++;
         if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
      end
      cyc();
      sb.push_back('{"lap_exit_live", mk(bcd(9), 1'b1, 1'b1, 1'b0, 1'b0)});
      btn_lap = 1'b1; cyc(); btn_lap = 1'b0;
      e = sb.pop_front(); n_chk++;
      if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
   endtask

   task automatic test_clear();
      exp_t e;
      cyc();
      sb.push_back('{"clear_to_idle", mk(bcd(0), 1'b0, 1'b0, 1'b0, 1'b0)});
      btn_clr = 1'b1; cyc(); btn_clr = 1'b0;
      e = sb.pop_front(); n_chk++;
      if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
      btn_ss = 1'b1; cyc(); btn_ss = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         cyc();
         pulse = 1'b1; cyc(); pulse = 1'b0;
      end
      sb.push_back('{"count_007", mk(bcd(7), 1'b1, 1'b1, 1'b0, 1'b0)});
      e = sb.pop_front(); n_chk++;
      if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
      cyc();
      sb.push_back('{"clear_priority", mk(bcd(0), 1'b0, 1'b0, 1'b0, 1'b0)});
      btn_clr = 1'b1; btn_ss = 1'b1; pulse = 1'b1;
      cyc();
      btn_clr = 1'b0; btn_ss = 1'b0; pulse = 1'b0;
      e = sb.pop_front(); n_chk++;
      if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
      sb.push_back('{"clear_stays_idle", mk(bcd(0), 1'b0, 1'b0, 1'b0, 1'b0)});
      cyc();
      e = sb.pop_front(); n_chk++;
      if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
   endtask

   task automatic test_reset_in_lap();
      exp_t e;
      btn_ss = 1'b1; cyc(); btn_ss = 1'b0;
      pulse = 1'b1; cyc(); pulse = 1'b0;
      btn_lap = 1'b1; cyc(); btn_lap = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cyc();
         pulse = 1'b1; cyc(); pulse = 1'b0;
      end
      sb.push_back('{"lap_hold_shown", mk(bcd(1), 1'b1, 1'b1, 1'b1, 1'b0)});
      e = sb.pop_front(); n_chk++;
      if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
      sb.push_back('{"reset_in_lap", mk(bcd(0), 1'b0, 1'b0, 1'b0, 1'b0)});
      rst = 1'b0; pulse = 1'b1; cyc(); pulse = 1'b0;
      e = sb.pop_front(); n_chk++;
      if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
      rst = 1'b1;
      sb.push_back('{"after_reset_idle", mk(bcd(0), 1'b0, 1'b0, 1'b0, 1'b0)});
      cyc();
      e = sb.pop_front(); n_chk++;
      if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
      btn_ss = 1'b1; cyc(); btn_ss = 1'b0;
      sb.push_back('{"no_residual", mk(bcd(1), 1'b1, 1'b1, 1'b0, 1'b0)});
      pulse = 1'b1; cyc(); pulse = 1'b0;
      e = sb.pop_front(); n_chk++;
      if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
   endtask

   task automatic test_overflow();
      exp_t e;
      bit   chk;
      cyc();
      btn_clr = 1'b1; cyc(); btn_clr = 1'b0;
      btn_ss = 1'b1; cyc(); btn_ss = 1'b0;
      for (int i = 1; i <= 119; i++) begin
         chk = (i == 9) || (i == 10) || (i == 59) || (i == 60) || (i == 119);
         if (chk) sb.push_back('{$sformatf("carry_%0d", i), mk(bcd(i), 1'b1, 1'b1, 1'b0, 1'b0)});
         pulse = 1'b1; cyc(); pulse = 1'b0;
         if (chk) begin
            e = sb.pop_front(); n_chk++;
            if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
         end
         cyc();
      end
      sb.push_back('{"wrap_overflow", mk(16'h0000, 1'b1, 1'b1, 1'b0, 1'b1)});
      pulse = 1'b1; cyc(); pulse = 1'b0;
      e = sb.pop_front(); n_chk++;
      if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
      sb.push_back('{"overflow_one_cycle", mk(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0)});
      cyc();
      e = sb.pop_front(); n_chk++;
      if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      sb.push_back('{"stop_with_tick", mk(bcd(1), 1'b0, 1'b0, 1'b0, 1'b0)});
      btn_ss = 1'b1; pulse = 1'b1; cyc(); btn_ss = 1'b0; pulse = 1'b0;
      e = sb.pop_front(); n_chk++;
      if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
      sb.push_back('{"lap_in_pause_ignored", mk(bcd(1), 1'b0, 1'b0, 1'b0, 1'b0)});
      btn_lap = 1'b1; cyc(); btn_lap = 1'b0;
      e = sb.pop_front(); n_chk++;
      if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
      sb.push_back('{"resume_again", mk(bcd(1), 1'b1, 1'b1, 1'b0, 1'b0)});
      btn_ss = 1'b1; cyc(); btn_ss = 1'b0;
      e = sb.pop_front(); n_chk++;
      if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
      cyc();
      sb.push_back('{"ss_beats_lap", mk(bcd(1), 1'b0, 1'b0, 1'b0, 1'b0)});
      btn_ss = 1'b1; btn_lap = 1'b1; cyc(); btn_ss = 1'b0; btn_lap = 1'b0;
      e = sb.pop_front(); n_chk++;
      if (obs() !== e.v) begin n_err++; $display("FAIL %s got=%h want=%h", e.name, obs(), e.v); end
   endtask

   initial begin
      rst     = 1'b0;
      btn_ss  = 1'b0;
      btn_clr = 1'b0;
      btn_lap = 1'b0;
      pulse   = 1'b0;
      test_reset();
      test_run();
      test_pause();
      test_lap();
      test_clear();
      test_reset_in_lap();
      test_overflow();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
